// File: rtl/key_pkg.sv
// Shared scan-code constants, default key codes and state types for the PS/2 key tracker.
package key_pkg;

  localparam logic [7:0] E0_PREFIX = 8'hE0;
  localparam logic [7:0] F0_PREFIX = 8'hF0;

  localparam logic [7:0] DEF_PLUS_CODE  = 8'h79;
  localparam logic [7:0] DEF_MINUS_CODE = 8'h7B;
  localparam logic [7:0] DEF_RIGHT_CODE = 8'h74;
  localparam logic [7:0] DEF_LEFT_CODE  = 8'h6B;
  localparam logic [7:0] DEF_START_CODE = 8'h5A;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} kbd_state_t;
  typedef enum logic [1:0] {NONE, PLUS, MINUS} dir_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == E0_PREFIX) || (b == F0_PREFIX);
  endfunction

endpackage

// File: rtl/scan_code_fsm.sv
// PS/2 prefix decoder (E0/F0) with an inter-byte timeout; emits one key_event strobe per
// completed make or break sequence, combinationally in the cycle of the final byte.
module scan_code_fsm
  import key_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       key_event,
  output logic [7:0] code,
  output logic       is_ext,
  output logic       is_break
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  kbd_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (byte_valid) begin
      cnt_d = '0;
      unique case (state_q)
        IDLE: begin
          if (byte_data == E0_PREFIX)      state_d = EXT;
          else if (byte_data == F0_PREFIX) state_d = BRK;
        end
        EXT: begin
          if (byte_data == F0_PREFIX)      state_d = EXT_BRK;
          else if (byte_data != E0_PREFIX) state_d = IDLE;
        end
        BRK, EXT_BRK: begin
          if (!is_prefix(byte_data)) state_d = IDLE;
        end
      endcase
    end else if (state_q != IDLE) begin
      // Abandon a stalled sequence without reporting anything.
      if (cnt_q == CntMax) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_comb begin
    key_event = byte_valid && !is_prefix(byte_data);
    code      = byte_data;
    is_ext    = (state_q == EXT) || (state_q == EXT_BRK);
    is_break  = (state_q == BRK) || (state_q == EXT_BRK);
  end

endmodule

// File: rtl/key_state_tracker.sv
// Tracks held steering/start keys from PS/2 bytes and presents frame-stable levels.
// Optional macro KEY_STICKY_PRESS_EN: keep sub-frame plus/minus taps visible for one frame.
module key_state_tracker
  import key_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50_000,
  parameter logic [7:0]  PLUS_CODE      = DEF_PLUS_CODE,
  parameter logic [7:0]  MINUS_CODE     = DEF_MINUS_CODE,
  parameter logic [7:0]  RIGHT_CODE     = DEF_RIGHT_CODE,
  parameter logic [7:0]  LEFT_CODE      = DEF_LEFT_CODE,
  parameter logic [7:0]  START_CODE     = DEF_START_CODE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       frame_start,
  output logic       plus_is_pressed,
  output logic       minus_is_pressed,
  output logic       start_pulse,
  output logic       raw_plus,
  output logic       raw_minus
);

  logic       key_event, is_ext, is_break;
  logic [7:0] code;

  scan_code_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_scan_code_fsm (
    .clk       (clk),
    .reset     (reset),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .key_event (key_event),
    .code      (code),
    .is_ext    (is_ext),
    .is_break  (is_break)
  );

  logic plus_held_q, right_held_q, minus_held_q, left_held_q, start_held_q;
  logic plus_held_d, right_held_d, minus_held_d, left_held_d, start_held_d;
  dir_t last_dir_q, last_dir_d;
  logic start_seen_q;
  logic hit_plus, hit_right, hit_minus, hit_left, hit_start;
  logic new_plus_make, new_minus_make, new_start_make;
  logic rp_next, rm_next;
  logic sticky_plus, sticky_minus;

  always_comb begin
    hit_plus  = key_event && !is_ext && (code == PLUS_CODE);
    hit_minus = key_event && !is_ext && (code == MINUS_CODE);
    hit_start = key_event && !is_ext && (code == START_CODE);
    hit_right = key_event &&  is_ext && (code == RIGHT_CODE);
    hit_left  = key_event &&  is_ext && (code == LEFT_CODE);

    plus_held_d  = hit_plus  ? !is_break : plus_held_q;
    right_held_d = hit_right ? !is_break : right_held_q;
    minus_held_d = hit_minus ? !is_break : minus_held_q;
    left_held_d  = hit_left  ? !is_break : left_held_q;
    start_held_d = hit_start ? !is_break : start_held_q;

    // Typematic repeats of a held key are not new makes.
    new_plus_make  = !is_break && ((hit_plus && !plus_held_q) || (hit_right && !right_held_q));
    new_minus_make = !is_break && ((hit_minus && !minus_held_q) || (hit_left && !left_held_q));
    new_start_make = !is_break && hit_start && !start_held_q;

    rp_next = plus_held_d | right_held_d;
    rm_next = minus_held_d | left_held_d;

    last_dir_d = last_dir_q;
    if (new_plus_make) begin
      last_dir_d = PLUS;
    end else if (new_minus_make) begin
      last_dir_d = MINUS;
    end else if (key_event && is_break) begin
      if (!rp_next && !rm_next)                     last_dir_d = NONE;
      else if ((last_dir_q == PLUS) && !rp_next)    last_dir_d = MINUS;
      else if ((last_dir_q == MINUS) && !rm_next)   last_dir_d = PLUS;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      plus_held_q  <= 1'b0;
      right_held_q <= 1'b0;
      minus_held_q <= 1'b0;
      left_held_q  <= 1'b0;
      start_held_q <= 1'b0;
      last_dir_q   <= NONE;
    end else begin
      plus_held_q  <= plus_held_d;
      right_held_q <= right_held_d;
      minus_held_q <= minus_held_d;
      left_held_q  <= left_held_d;
      start_held_q <= start_held_d;
      last_dir_q   <= last_dir_d;
    end
  end

  assign raw_plus  = plus_held_q | right_held_q;
  assign raw_minus = minus_held_q | left_held_q;

`ifdef KEY_STICKY_PRESS_EN
  logic cap_plus_q, cap_minus_q;

  // A make coinciding with frame_start is captured for the following frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_plus_q  <= 1'b0;
      cap_minus_q <= 1'b0;
    end else if (frame_start) begin
      cap_plus_q  <= new_plus_make;
      cap_minus_q <= new_minus_make;
    end else begin
      cap_plus_q  <= cap_plus_q | new_plus_make;
      cap_minus_q <= cap_minus_q | new_minus_make;
    end
  end

  assign sticky_plus  = cap_plus_q;
  assign sticky_minus = cap_minus_q;
`else
  assign sticky_plus  = 1'b0;
  assign sticky_minus = 1'b0;
`endif

  // Frame registers sample the pre-update held state when a byte coincides with frame_start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      plus_is_pressed  <= 1'b0;
      minus_is_pressed <= 1'b0;
      start_pulse      <= 1'b0;
      start_seen_q     <= 1'b0;
    end else if (frame_start) begin
      plus_is_pressed  <= (raw_plus & (!raw_minus | (last_dir_q == PLUS))) | sticky_plus;
      minus_is_pressed <= (raw_minus & (!raw_plus | (last_dir_q == MINUS))) | sticky_minus;
      start_pulse      <= start_seen_q;
      start_seen_q     <= new_start_make;
    end else begin
      start_seen_q     <= start_seen_q | new_start_make;
    end
  end

endmodule
